// File: rtl/z88_kb_pkg.sv
// Shared definitions for the PS/2 to Z88 key matrix front end: prefix codes,
// receive FSM states, matrix index type and the scan-code set 2 key map.
package z88_kb_pkg;

  typedef logic [5:0] kb_idx_t;

  typedef struct packed {
    logic    valid;
    kb_idx_t idx;
  } kb_map_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;  // extended-key prefix
  localparam logic [7:0] CODE_BRK = 8'hF0;  // key-release prefix
  localparam logic [7:0] CODE_OVR = 8'hFF;  // keyboard buffer overrun

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
           (code == 8'hEE) || (code == 8'h00);
  endfunction

  // Scan-code set 2 (with E0 extension flag) to matrix bit index (row*8+col).
  function automatic kb_map_t ps2_to_idx(input logic ext, input logic [7:0] code);
    kb_map_t m;
    m = '{valid: 1'b0, idx: 6'd0};
    case ({ext, code})
      9'h01C: m = '{valid: 1'b1, idx: 6'd45};  // A
      9'h05A: m = '{valid: 1'b1, idx: 6'd6};   // ENTER
      9'h012: m = '{valid: 1'b1, idx: 6'd54};  // left SHIFT
      9'h059: m = '{valid: 1'b1, idx: 6'd63};  // right SHIFT
      9'h029: m = '{valid: 1'b1, idx: 6'd46};  // SPACE
      9'h066: m = '{valid: 1'b1, idx: 6'd7};   // BACKSPACE -> DEL
      9'h00D: m = '{valid: 1'b1, idx: 6'd53};  // TAB
      9'h076: m = '{valid: 1'b1, idx: 6'd61};  // ESC
      9'h01B: m = '{valid: 1'b1, idx: 6'd44};  // S
      9'h023: m = '{valid: 1'b1, idx: 6'd43};  // D
      9'h02B: m = '{valid: 1'b1, idx: 6'd42};  // F
      9'h034: m = '{valid: 1'b1, idx: 6'd27};  // G
      9'h016: m = '{valid: 1'b1, idx: 6'd37};  // 1
      9'h01E: m = '{valid: 1'b1, idx: 6'd36};  // 2
      9'h175: m = '{valid: 1'b1, idx: 6'd59};  // UP
      9'h172: m = '{valid: 1'b1, idx: 6'd58};  // DOWN
      9'h16B: m = '{valid: 1'b1, idx: 6'd56};  // LEFT
      9'h174: m = '{valid: 1'b1, idx: 6'd57};  // RIGHT
      default: m = '{valid: 1'b0, idx: 6'd0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: pin synchronisers, clock glitch filter,
// 11-bit frame FSM with odd-parity/stop check and inter-edge timeout.
// Bytes leave as a one-cycle scan_valid pulse with scan_code held afterwards;
// bad frames leave as a one-cycle frame_err pulse (never both at once).
module ps2_rx
  import z88_kb_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  rx_state_t     state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          valid_q, valid_d;
  logic [7:0]    code_q, code_d;
  logic          err_q, err_d;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ck_s1_q <= 1'b1;
      ck_s2_q <= 1'b1;
      dt_s1_q <= 1'b1;
      dt_s2_q <= 1'b1;
    end else begin
      ck_s1_q <= ps2clk;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= ps2dat;
      dt_s2_q <= dt_s1_q;
    end
  end

  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (ck_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ck_s2_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Frame FSM next state: one bit per filtered falling edge, timeout otherwise.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tcnt_d  = tcnt_q;
    valid_d = 1'b0;
    code_d  = code_q;
    err_d   = 1'b0;
    if (fall) begin
      tcnt_d = '0;
      case (state_q)
        RX_IDLE: begin
          if (!dt_s2_q) begin
            state_d = RX_DATA;
            bcnt_d  = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d = {dt_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dt_s2_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dt_s2_q && (^{shift_q, par_q})) begin
            valid_d = 1'b1;
            code_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = RX_IDLE;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      state_q <= RX_IDLE;
      bcnt_q  <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign scan_valid = valid_q;
  assign scan_code  = code_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard to Z88 64-key matrix image. Received bytes are decoded with
// E0 (extended) and F0 (break) prefix flags; matrix bit = 0 while pressed.
module ps2_keymatrix
  import z88_kb_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2clk,
  input  logic        ps2dat,
  output logic [63:0] kbmat,
  output logic        scan_valid,
  output logic [7:0]  scan_code,
  output logic        frame_err
);

  logic [63:0] kbmat_q, kbmat_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  kb_map_t     hit;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  // Decoder: prefixes set flags, key codes update one matrix bit and clear flags.
  always_comb begin
    kbmat_d = kbmat_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    hit     = ps2_to_idx(ext_q, scan_code);
    if (scan_valid) begin
      if (scan_code == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code == CODE_BRK) begin
        brk_d = 1'b1;
      end else if (scan_code == CODE_OVR) begin
        kbmat_d = '1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else if (!is_ignored(scan_code)) begin
        if (hit.valid) kbmat_d[hit.idx] = brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Matrix and prefix flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbmat_q <= '1;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      kbmat_q <= kbmat_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  assign kbmat = kbmat_q;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: table of directed frames, hand-written timeout,
// glitch, overrun and reset sequences, then random frames against a model.
module tb_ps2_keymatrix;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2clk = 1'b1;
  logic        ps2dat = 1'b1;
  logic [63:0] kbmat;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        frame_err;

  ps2_keymatrix #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .kbmat     (kbmat),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: key map, prefix flags and expected matrix.
  int          map_idx[int];
  int          map_keys[$];
  bit          m_ext, m_brk;
  logic [63:0] m_kb = '1;

  task automatic model_apply(input logic [7:0] c);
    int key;
    if (c == 8'hE0) m_ext = 1'b1;
    else if (c == 8'hF0) m_brk = 1'b1;
    else if (c == 8'hFF) begin
      m_kb = '1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (c == 8'hAA || c == 8'hFA || c == 8'hFE || c == 8'hEE || c == 8'h00) begin
    end else begin
      key = (m_ext ? 256 : 0) + int'(c);
      if (map_idx.exists(key)) m_kb[map_idx[key]] = m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // Scoreboard
  logic [7:0] exp_q[$];
  int         n_valid = 0;
  int         n_err = 0;
  int         exp_err = 0;
  bit         kb_due = 1'b0;

  // Monitor: scan_code against expected queue, kbmat unchanged at N+1, updated at N+2.
  always @(negedge clk) begin
    logic [7:0] e;
    if (kb_due) begin
      kb_due = 1'b0;
      check("kbmat_after_byte", kbmat, m_kb);
    end
    if (scan_valid && frame_err) begin
      n_checks++; n_errors++;
      $display("FAIL valid_err_overlap: got both high expected exclusive");
    end
    if (frame_err) n_err++;
    if (scan_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_valid: got scan_code %h expected no byte", scan_code);
      end else begin
        e = exp_q.pop_front();
        check("scan_code", {56'd0, scan_code}, {56'd0, e});
        check("kbmat_hold_n1", kbmat, m_kb);
        model_apply(e);
        kb_due = 1'b1;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_kb = '1; m_ext = 1'b0; m_brk = 1'b0;
    exp_q.delete();
    kb_due = 1'b0;
  endtask

  // One PS/2 bit: data set with clock high, then clock low; optional FL-1 glitches.
  task automatic ps2_bit(input logic b, input bit gl);
    ps2dat = b;
    if (gl) begin
      wait_cyc(15); ps2clk = 1'b0; wait_cyc(FL - 1); ps2clk = 1'b1; wait_cyc(HALF - 15 - (FL - 1));
    end else wait_cyc(HALF);
    ps2clk = 1'b0;
    if (gl) begin
      wait_cyc(15); ps2clk = 1'b1; wait_cyc(FL - 1); ps2clk = 1'b0; wait_cyc(HALF - 15 - (FL - 1));
    end else wait_cyc(HALF);
    ps2clk = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^c) ^ bad_par;
    return {~bad_stop, par, c, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop, input bit gl);
    logic [10:0] f;
    f = make_frame(c, bad_par, bad_stop);
    if (!bad_par && !bad_stop) exp_q.push_back(c);
    else exp_err++;
    for (int i = 0; i < 11; i++) ps2_bit(f[i], gl);
    ps2dat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err_count"}, 64'(n_err), 64'(exp_err));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  code;
    bit          bad_par;
    bit          bad_stop;
    bit          exp_valid;
    logic [7:0]  exp_code;
    logic [63:0] exp_kb;
  } vec_t;

  vec_t vt[12];

  function automatic logic [63:0] kclr(input int i);
    logic [63:0] m;
    m = '1;
    m[i] = 1'b0;
    return m;
  endfunction

  initial begin
    int nv0, ne0, got, r;
    logic [7:0] c;
    logic [10:0] f;
    logic [7:0] ign[5];

    map_idx[32'h01C] = 45; map_idx[32'h05A] = 6;  map_idx[32'h012] = 54;
    map_idx[32'h059] = 63; map_idx[32'h029] = 46; map_idx[32'h066] = 7;
    map_idx[32'h00D] = 53; map_idx[32'h076] = 61; map_idx[32'h01B] = 44;
    map_idx[32'h023] = 43; map_idx[32'h02B] = 42; map_idx[32'h034] = 27;
    map_idx[32'h016] = 37; map_idx[32'h01E] = 36; map_idx[32'h175] = 59;
    map_idx[32'h172] = 58; map_idx[32'h16B] = 56; map_idx[32'h174] = 57;
    foreach (map_idx[k]) map_keys.push_back(k);
    ign[0] = 8'hAA; ign[1] = 8'hFA; ign[2] = 8'hFE; ign[3] = 8'hEE; ign[4] = 8'h00;

    vt[0]  = '{8'h1C, 0, 0, 1, 8'h1C, kclr(45)};
    vt[1]  = '{8'hF0, 0, 0, 1, 8'hF0, kclr(45)};
    vt[2]  = '{8'h1C, 0, 0, 1, 8'h1C, '1};
    vt[3]  = '{8'h5A, 0, 0, 1, 8'h5A, kclr(6)};
    vt[4]  = '{8'hE0, 0, 0, 1, 8'hE0, kclr(6)};
    vt[5]  = '{8'h75, 0, 0, 1, 8'h75, kclr(6) & kclr(59)};
    vt[6]  = '{8'hE0, 0, 0, 1, 8'hE0, kclr(6) & kclr(59)};
    vt[7]  = '{8'hF0, 0, 0, 1, 8'hF0, kclr(6) & kclr(59)};
    vt[8]  = '{8'h75, 0, 0, 1, 8'h75, kclr(6)};
    vt[9]  = '{8'h1C, 0, 0, 1, 8'h1C, kclr(6) & kclr(45)};
    vt[10] = '{8'h1C, 1, 0, 0, 8'h1C, kclr(6) & kclr(45)};
    vt[11] = '{8'h1C, 0, 1, 0, 8'h1C, kclr(6) & kclr(45)};

    // Reset state
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);
    check("rst_kbmat", kbmat, '1);
    check("rst_scan_valid", 64'(scan_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_scan_code", 64'(scan_code), 64'd0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      nv0 = n_valid; ne0 = n_err;
      send_frame(vt[i].code, vt[i].bad_par, vt[i].bad_stop, 1'b0);
      check($sformatf("vec%0d_valid_pulses", i), 64'(n_valid - nv0), 64'(vt[i].exp_valid));
      check($sformatf("vec%0d_err_pulses", i), 64'(n_err - ne0), 64'(!vt[i].exp_valid));
      check($sformatf("vec%0d_scan_code", i), 64'(scan_code), 64'(vt[i].exp_code));
      check($sformatf("vec%0d_kbmat", i), kbmat, vt[i].exp_kb);
    end
    check_counts("table");

    // Timeout: start + 4 data bits, then the 5th falling edge is the last one
    f = make_frame(8'h29, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(f[i], 1'b0);
    ps2dat = f[4];
    wait_cyc(HALF);
    ps2clk = 1'b0;
    got = 0;
    for (int k = 1; k <= FL + 2 + TO + 10; k++) begin
      @(negedge clk);
      if (k == HALF) ps2clk = 1'b1;
      if (frame_err && got == 0) got = k;
    end
    exp_err++;
    ps2dat = 1'b1;
    check("timeout_latency", 64'(got), 64'(FL + 2 + TO));
    check_counts("timeout");
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check("after_timeout_bit46", 64'(kbmat[46]), 64'd0);
    check("after_timeout_kbmat", kbmat, m_kb);
    check_counts("after_timeout");

    // Glitches during a valid frame, overrun, then a key after overrun
    nv0 = n_valid;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    check("glitch_valid_pulses", 64'(n_valid - nv0), 64'd1);
    check("glitch_scan_code", 64'(scan_code), 64'h12);
    check("glitch_bit54", 64'(kbmat[54]), 64'd0);
    check_counts("glitch");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    check("overrun_kbmat", kbmat, '1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("post_overrun_make", kbmat, kclr(45));
    check_counts("overrun");

    // Reset in the middle of a frame
    f = make_frame(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(f[i], 1'b0);
    ps2dat = f[6];
    wait_cyc(HALF);
    ps2clk = 1'b0;
    wait_cyc(3);
    nv0 = n_valid; ne0 = n_err;
    do_reset();
    ps2clk = 1'b1;
    ps2dat = 1'b1;
    wait_cyc(TO + 100);
    check("midreset_valid_pulses", 64'(n_valid - nv0), 64'd0);
    check("midreset_err_pulses", 64'(n_err - ne0), 64'd0);
    check("midreset_kbmat", kbmat, '1);
    check("midreset_scan_code", 64'(scan_code), 64'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("post_reset_make", kbmat, kclr(6));
    check_counts("post_reset");

    // Random frames against the model
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 15);
      if (r < 6) c = 8'(map_keys[$urandom_range(0, map_keys.size() - 1)] % 256);
      else if (r < 9) c = 8'hE0;
      else if (r < 11) c = 8'hF0;
      else if (r < 12) c = ign[$urandom_range(0, 4)];
      else c = 8'($urandom_range(0, 255));
      send_frame(c, r == 15, r == 14, 1'b0);
      check($sformatf("rnd%0d_kbmat", i), kbmat, m_kb);
      check_counts($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
